// File: rtl/register_file_pkg.sv
// Shared constants for the 32-entry MIPS register file.
// Defines the address width, register count and the hardwired zero index.
package register_file_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH     = 5;
  localparam int NUM_REGS           = 32;

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read mux of the register file.
// Ports: addr_i selects an entry of regs_i; rdata_o is 0 for address 0.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [REG_ADDR_WIDTH-1:0]            addr_i,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_i,
  output logic [DATA_WIDTH-1:0]                rdata_o
);

  always_comb begin
    rdata_o = '0;
    if (addr_i != ZERO_REG) begin
      rdata_o = regs_i[addr_i];
    end
  end

endmodule

// File: rtl/register_file.sv
// MIPS-style 32x DATA_WIDTH register file: two async reads, one sync write.
// Ports: clk, rst (async high), we/rd/data write, rs->a and rt->b reads.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [REG_ADDR_WIDTH-1:0] rt,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0]     data,
  output logic [DATA_WIDTH-1:0]     a,
  output logic [DATA_WIDTH-1:0]     b
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_d;

  // Entry 0 is pinned to zero in the next state so it can never hold data.
  always_comb begin
    regs_d = regs_q;
    if (we && (rd != ZERO_REG)) begin
      regs_d[rd] = data;
    end
    regs_d[ZERO_REG] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  register_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_port_a (
    .addr_i  (rs),
    .regs_i  (regs_q),
    .rdata_o (a)
  );

  register_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_port_b (
    .addr_i  (rt),
    .regs_i  (regs_q),
    .rdata_o (b)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
// Drives inputs on the falling edge and samples shortly after edges.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] data;
  logic [31:0] a;
  logic [31:0] b;

  int vectors;
  int miscompares;

  register_file #(.DATA_WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .rs   (rs),
    .rt   (rt),
    .rd   (rd),
    .data (data),
    .a    (a),
    .b    (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; we = 1'b0;
    rs = 5'd0; rt = 5'd0; rd = 5'd0; data = 32'd0;
    #1;
    for (int i = 0; i < 32; i++) begin
      rs = i[4:0];
      rt = 5'(31 - i);
      #1;
      vectors++;
      if (a !== 32'd0 || b !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_read addr=%0d a=%h b=%h want 0", i, a, b);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    logic [4:0]  wa [4];
    logic [31:0] wd [4];
    wa = '{5'd1, 5'd2, 5'd6, 5'd8};
    wd = '{32'd2001, 32'd4001, 32'd5001, 32'd3001};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      we = 1'b1; rd = wa[i]; data = wd[i];
      rs = wa[i]; rt = wa[i];
      @(posedge clk); #1;
      vectors++;
      if (a !== wd[i] || b !== wd[i]) begin
        miscompares++;
        $display("FAIL wr_after_edge r%0d a=%0d b=%0d want %0d",
                 wa[i], a, b, wd[i]);
      end
    end
    @(negedge clk);
    we = 1'b0;
    rs = 5'd1; rt = 5'd2; #1;
    vectors++;
    if (a !== 32'd2001 || b !== 32'd4001) begin
      miscompares++;
      $display("FAIL rd_r1_r2 a=%0d b=%0d want 2001/4001", a, b);
    end
    rs = 5'd6; rt = 5'd8; #1;
    vectors++;
    if (a !== 32'd5001 || b !== 32'd3001) begin
      miscompares++;
      $display("FAIL rd_r6_r8 a=%0d b=%0d want 5001/3001", a, b);
    end
  endtask

  task automatic test_write_disable();
    logic [4:0]  wa [4];
    logic [31:0] wd [4];
    wa = '{5'd1, 5'd2, 5'd6, 5'd8};
    wd = '{32'd2001, 32'd4001, 32'd5001, 32'd3001};
    we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rd = wa[i]; data = wd[i];
      @(negedge clk);
      data = 32'd0;
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rs = wa[i]; rt = wa[i]; #1;
      vectors++;
      if (a !== wd[i] || b !== wd[i]) begin
        miscompares++;
        $display("FAIL we0_hold r%0d a=%0d b=%0d want %0d",
                 wa[i], a, b, wd[i]);
      end
    end
  endtask

  task automatic test_reg0();
    @(negedge clk);
    we = 1'b1; rd = 5'd0; data = 32'hDEADBEEF;
    @(posedge clk); #1;
    @(negedge clk);
    we = 1'b0; rs = 5'd0; rt = 5'd0; #1;
    vectors++;
    if (a !== 32'd0 || b !== 32'd0) begin
      miscompares++;
      $display("FAIL reg0 a=%h b=%h want 0", a, b);
    end
    rs = 5'd1; #1;
    vectors++;
    if (a !== 32'd2001) begin
      miscompares++;
      $display("FAIL reg0_side r1=%0d want 2001", a);
    end
  endtask

  task automatic test_read_during_write();
    @(negedge clk);
    we = 1'b1; rd = 5'd3; data = 32'd11;
    @(negedge clk);
    rs = 5'd3; rt = 5'd3; data = 32'd7; #1;
    vectors++;
    if (a !== 32'd11) begin
      miscompares++;
      $display("FAIL rdw_before a=%0d want 11", a);
    end
    @(posedge clk); #1;
    vectors++;
    if (a !== 32'd7 || b !== 32'd7) begin
      miscompares++;
      $display("FAIL rdw_after a=%0d b=%0d want 7", a, b);
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rs = 5'd1; rt = 5'd2; #2;
    rst = 1'b1; #1;
    vectors++;
    if (a !== 32'd0 || b !== 32'd0) begin
      miscompares++;
      $display("FAIL async_rst a=%0d b=%0d want 0", a, b);
    end
  endtask

  task automatic test_reset_pending();
    we = 1'b1; rd = 5'd5; data = 32'd99;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0; we = 1'b0; rs = 5'd5; rt = 5'd8; #1;
    vectors++;
    if (a !== 32'd0 || b !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_pending r5=%0d r8=%0d want 0", a, b);
    end
    we = 1'b1; rd = 5'd5; data = 32'd123;
    @(posedge clk); #1;
    vectors++;
    if (a !== 32'd123) begin
      miscompares++;
      $display("FAIL first_wr_after_rst r5=%0d want 123", a);
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_write_read();
    test_write_disable();
    test_reg0();
    test_read_during_write();
    test_async_reset();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
